// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice.
// Opcodes, flag bit positions and arbiter FSM states.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_OPW = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_NEG = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;

  localparam int F_Z = 3;
  localparam int F_C = 2;
  localparam int F_V = 1;
  localparam int F_S = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU with {Z,C,V,S} flags.
// Illegal opcode yields err=1 with zero result and flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum   = {1'b0, in1} + {1'b0, in2};
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    unique case (1'b1)
      (op == ALU_ADD): begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (in1[WIDTH-1] == in2[WIDTH-1])
              & (res[WIDTH-1] != in1[WIDTH-1]);
      end
      (op == ALU_NEG): begin
        res = '0 - in1;
        ovf = (in1 == {1'b1, {(WIDTH-1){1'b0}}});
      end
      (op == ALU_AND): res = in1 & in2;
      (op == ALU_XOR): res = in1 ^ in2;
      (op == ALU_SHL): res = in1 << in2;
      (op == ALU_SHR): res = in1 >> in2;
      (op == ALU_SRA): begin
        // Legacy rule: logical shift, then only the top bit is restored.
        res = in1 >> in2;
        res[WIDTH-1] = in1[WIDTH-1];
      end
      default: err = 1'b1;
    endcase
    out   = res;
    flags = '0;
    if (!err) begin
      flags[F_Z] = (res == '0);
      flags[F_C] = carry;
      flags[F_V] = ovf;
      flags[F_S] = res[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between execute and address units.
// Latches the winner, runs one EXEC cycle, holds the response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_setf,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_setf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [3:0]       flags_q
);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             gnt0;
  logic             gnt1;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             setf_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic             alu_err;

  alu #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_alu (
    .op   (op_q),
    .in1  (a_q),
    .in2  (b_q),
    .out  (alu_out),
    .flags(alu_flags),
    .err  (alu_err)
  );

  always_comb begin
    gnt0       = req0_valid & (~req1_valid | last_grant);
    gnt1       = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nx   = state;
    unique case (state)
      IDLE: begin
        req0_ready = rst_n & gnt0;
        req1_ready = rst_n & gnt1;
        if (gnt0 | gnt1) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      setf_q     <= 1'b0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      flags_q    <= '0;
    end else begin
      if (state == IDLE && (gnt0 | gnt1)) begin
        op_q       <= gnt1 ? req1_op   : req0_op;
        a_q        <= gnt1 ? req1_a    : req0_a;
        b_q        <= gnt1 ? req1_b    : req0_b;
        setf_q     <= gnt1 ? req1_setf : req0_setf;
        id_q       <= gnt1;
        last_grant <= gnt1;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_out   <= alu_out;
        rsp_flags <= alu_flags;
        rsp_err   <= alu_err;
        if (setf_q && !alu_err) flags_q <= alu_flags;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural model.
// Directed scenarios followed by randomized traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_out;
  logic [3:0]  rsp_flags, flags_q;

  logic        p_v[2];
  logic [2:0]  p_op[2];
  logic [31:0] p_a[2];
  logic [31:0] p_b[2];
  logic        p_setf[2];

  int total = 0;
  int bad = 0;
  int m_last;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(p_v[0]),
    .req0_ready(req0_ready),
    .req0_op   (p_op[0]),
    .req0_a    (p_a[0]),
    .req0_b    (p_b[0]),
    .req0_setf (p_setf[0]),
    .req1_valid(p_v[1]),
    .req1_ready(req1_ready),
    .req1_op   (p_op[1]),
    .req1_a    (p_a[1]),
    .req1_b    (p_b[1]),
    .req1_setf (p_setf[1]),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .flags_q   (flags_q)
  );

  // Returns {err, Z, C, V, S, result}
  function automatic logic [36:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    longint sx;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        sx = longint'($signed(a)) + longint'($signed(b));
        v = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
      end
      3'd1: begin
        r = 32'd0 - a;
        v = (a == 32'h8000_0000);
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = (b >= 32) ? 32'd0 : (a << b);
      3'd5: r = (b >= 32) ? 32'd0 : (a >> b);
      3'd6: r = ((b >= 32) ? 32'd0 : (a >> b)) | {a[31], 31'd0};
      default: return {1'b1, 4'b0000, 32'd0};
    endcase
    return {1'b0, (r == 32'd0), c, v, r[31], r};
  endfunction

  task automatic set_port(input int p, input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic setf);
    p_v[p] = v; p_op[p] = op; p_a[p] = a; p_b[p] = b; p_setf[p] = setf;
  endtask

  // One full transaction: grant, EXEC, response, optional stall, accept.
  task automatic do_op(input int hold, input string tag);
    int g;
    logic [36:0] exp;
    logic [36:0] got;
    logic esetf;
    #1;
    g = (p_v[0] && p_v[1]) ? (1 - m_last) : (p_v[1] ? 1 : 0);
    total++;
    if ({req1_ready, req0_ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin
      bad++;
      $display("FAIL %s grant: ready=%b%b want port %0d", tag,
               req1_ready, req0_ready, g);
    end
    m_last = g;
    exp = model(p_op[g], p_a[g], p_b[g]);
    esetf = p_setf[g];
    @(posedge clk); #1;
    p_v[g] = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s exec: rsp_valid=%b rdy=%b%b want 0 00", tag,
               rsp_valid, req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    if (esetf && !exp[36]) m_flags = exp[35:32];
    got = {rsp_err, rsp_flags, rsp_out};
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== g[0] || got !== exp) begin
      bad++;
      $display("FAIL %s rsp: v=%b id=%b err/flags/out=%h want v=1 id=%0d %h",
               tag, rsp_valid, rsp_id, got, g, exp);
    end
    total++;
    if (flags_q !== m_flags) begin
      bad++;
      $display("FAIL %s flags_q: got %b want %b", tag, flags_q, m_flags);
    end
    for (int i = 0; i < hold; i++) begin
      p_v[0] = 1'b1; p_v[1] = 1'b1;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      got = {rsp_err, rsp_flags, rsp_out};
      total++;
      if (rsp_valid !== 1'b1 || got !== exp || flags_q !== m_flags
          || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold%0d: v=%b rsp=%h fq=%b rdy=%b%b want 1 %h %b 00",
                 tag, i, rsp_valid, got, flags_q, req1_ready, req0_ready,
                 exp, m_flags);
      end
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: rsp_valid=%b want 0", tag, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_port(0, 1'b1, 3'd0, 32'd1, 32'd1, 1'b1);
    set_port(1, 1'b1, 3'd0, 32'd2, 32'd2, 1'b1);
    @(posedge clk); #1;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset ready: got %b%b want 00", req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_out, rsp_flags, flags_q} !== '0) begin
      bad++;
      $display("FAIL reset outs: v=%b id=%b err=%b out=%h fl=%b fq=%b want 0",
               rsp_valid, rsp_id, rsp_err, rsp_out, rsp_flags, flags_q);
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    rst_n = 1'b1;
    m_last = 1;
    m_flags = 4'b0000;
  endtask

  task automatic test_add_carry();
    test_reset();
    set_port(0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    do_op(0, "add_carry");
    total++;
    if (flags_q !== 4'b1100) begin
      bad++;
      $display("FAIL add_carry fq: got %b want 1100", flags_q);
    end
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 3'd2, $urandom, $urandom, 1'b0);
      set_port(1, 1'b1, 3'd2, $urandom, $urandom, 1'b0);
      do_op(0, "round_robin");
    end
  endtask

  task automatic test_stall();
    set_port(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    set_port(1, 1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(5, "stall_ovf");
  endtask

  task automatic test_illegal();
    set_port(0, 1'b1, 3'd2, 32'h0000_00F0, 32'h0000_000F, 1'b1);
    do_op(0, "zero_setf");
    set_port(0, 1'b1, 3'd7, 32'h1234_5678, 32'h9, 1'b1);
    do_op(1, "illegal");
    total++;
    if (flags_q !== 4'b1000) begin
      bad++;
      $display("FAIL illegal fq: got %b want 1000", flags_q);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    seen = 1'b0;
    set_port(0, 1'b1, 3'd0, 32'd5, 32'd6, 1'b1);
    #1;
    total++;
    if (req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst grant: ready0=%b want 1", req0_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    p_v[0] = 1'b1; p_v[1] = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst ready: got %b%b want 00", req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || flags_q !== 4'b0000) begin
      bad++;
      $display("FAIL midrst state: v=%b fq=%b want 0 0000", rsp_valid, flags_q);
    end
    rst_n = 1'b1;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    m_last = 1;
    m_flags = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midrst lost op: rsp_valid seen=1 want 0");
    end
    set_port(1, 1'b1, 3'd3, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
    do_op(0, "after_rst");
  endtask

  task automatic test_sra();
    set_port(0, 1'b1, 3'd6, 32'h8000_0010, 32'd4, 1'b0);
    do_op(0, "sra");
    set_port(0, 1'b1, 3'd4, 32'h0000_0001, 32'd40, 1'b1);
    do_op(0, "shl_wide");
    set_port(1, 1'b1, 3'd1, 32'h8000_0000, 32'd0, 1'b1);
    do_op(0, "neg_min");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        op = 3'($urandom_range(0, 7));
        b = (op >= 3'd4) ? 32'($urandom_range(0, 40)) : $urandom;
        set_port(p, 1'($urandom), op, $urandom, b, 1'($urandom));
      end
      if (!p_v[0] && !p_v[1]) p_v[$urandom_range(0, 1)] = 1'b1;
      do_op($urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    m_last = 1;
    m_flags = 4'b0000;
    test_add_carry();
    test_round_robin();
    test_stall();
    test_illegal();
    test_reset_mid_op();
    test_sra();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
